// File: rtl/pi_pkg.sv
// Shared definitions for the pi lane permuter.
// Holds the lane count, the length of the pi cycle, the cycle start
// coordinate p0, the FSM state encoding, the lane index helper and a
// mod-5 adder on 3-bit coordinates.
package pi_pkg;

    localparam int         LANES     = 25;
    localparam logic [4:0] CYCLE_LEN = 5'd24;
    localparam logic [2:0] P0_X      = 3'd1;
    localparam logic [2:0] P0_Y      = 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_WALK  = 2'd2,
        ST_DONE  = 2'd3
    } pi_state_e;

    // Lane (x,y) lives at index 5*x+y of the flat line.
    function automatic logic [4:0] lane_idx(input logic [2:0] x, input logic [2:0] y);
        return ({2'b00, x} << 2) + {2'b00, x} + {2'b00, y};
    endfunction

    // (a+b) mod 5 for a,b in 0..4 without leaving 3 bits:
    // when a+b would reach 5 or more, a >= 5-b, and the result is a-(5-b).
    function automatic logic [2:0] add_mod5(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] r;
        if (a >= (3'd5 - b)) begin
            r = a - (3'd5 - b);
        end else begin
            r = a + b;
        end
        return r;
    endfunction

endpackage

// File: rtl/pi_next_coord.sv
// Successor coordinate on the 24-lane pi cycle.
// Ports:
//   x_i, y_i    current coordinate (0..4 each)
//   inverse_i   0: forward pi step, 1: inverse pi step
//   x_o, y_o    next coordinate
// Forward:  (x,y) -> (y, 2x+3y)
// Inverse:  (x,y) -> (x+3y, x)
module pi_next_coord
    import pi_pkg::*;
(
    input  logic [2:0] x_i,
    input  logic [2:0] y_i,
    input  logic       inverse_i,
    output logic [2:0] x_o,
    output logic [2:0] y_o
);

    logic [2:0] x2_s;
    logic [2:0] y2_s;
    logic [2:0] y3_s;

    // Build 2x and 3y from chained mod-5 additions, then select the direction.
    always_comb begin
        x2_s = add_mod5(x_i, x_i);
        y2_s = add_mod5(y_i, y_i);
        y3_s = add_mod5(y2_s, y_i);
        x_o  = 3'd0;
        y_o  = 3'd0;
        if (inverse_i) begin
            x_o = add_mod5(x_i, y3_s);
            y_o = x_i;
        end else begin
            x_o = y_i;
            y_o = add_mod5(x2_s, y3_s);
        end
    end

endmodule

// File: rtl/pi_lane_permuter.sv
// In-place Keccak pi permutation over a 5x5 state of LANE_W-bit lanes.
// The 24 non-origin lanes form a single cycle under pi, so the result is
// produced by one hold lane rotating values around that cycle.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   load       capture line_in into the state (idle only)
//   line_in    flat state, lane (x,y) at [(5x+y)*LANE_W +: LANE_W]
//   start      begin a permutation (idle only, load has priority)
//   inverse    sampled with start: 0 = pi, 1 = pi^-1 (needs INV_EN)
//   busy       high during PRIME and WALK
//   done       one-cycle pulse when state_out holds the result
//   state_out  state register, same packing as line_in
//   step_cnt   walk steps completed, 0..24
module pi_lane_permuter
    import pi_pkg::*;
#(
    parameter int LANE_W = 1,
    parameter bit INV_EN = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [LANES*LANE_W-1:0]  line_in,
    input  logic                     start,
    input  logic                     inverse,
    output logic                     busy,
    output logic                     done,
    output logic [LANES*LANE_W-1:0]  state_out,
    output logic [4:0]               step_cnt
);

    localparam int P0_BASE = int'(lane_idx(P0_X, P0_Y)) * LANE_W;

    pi_state_e                 fsm_q,   fsm_d;
    logic [LANES*LANE_W-1:0]   state_q, state_d;
    logic [LANE_W-1:0]         hold_q,  hold_d;
    logic [2:0]                px_q,    px_d;
    logic [2:0]                py_q,    py_d;
    logic                      inv_q,   inv_d;
    logic [4:0]                step_q,  step_d;
    logic                      busy_q,  busy_d;
    logic                      done_q,  done_d;

    logic [2:0]                nx_s;
    logic [2:0]                ny_s;
    int                        d_base_s;

    pi_next_coord u_next (
        .x_i       (px_q),
        .y_i       (py_q),
        .inverse_i (inv_q),
        .x_o       (nx_s),
        .y_o       (ny_s)
    );

    // Bit offset of the destination lane for the current walk step.
    always_comb begin
        d_base_s = int'(lane_idx(nx_s, ny_s)) * LANE_W;
    end

    // Next-state logic for the FSM, the state file, the hold lane and the counter.
    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        hold_d  = hold_q;
        px_d    = px_q;
        py_d    = py_q;
        inv_d   = inv_q;
        step_d  = step_q;
        case (fsm_q)
            ST_IDLE: begin
                if (load) begin
                    state_d = line_in;
                end else if (start) begin
                    inv_d  = inverse & INV_EN;
                    px_d   = P0_X;
                    py_d   = P0_Y;
                    step_d = 5'd0;
                    fsm_d  = ST_PRIME;
                end else begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_PRIME: begin
                hold_d = state_q[P0_BASE +: LANE_W];
                fsm_d  = ST_WALK;
            end
            ST_WALK: begin
                // Drop the carried lane into its destination and pick up the one it displaces.
                state_d[d_base_s +: LANE_W] = hold_q;
                hold_d = state_q[d_base_s +: LANE_W];
                px_d   = nx_s;
                py_d   = ny_s;
                step_d = step_q + 5'd1;
                if (step_q == (CYCLE_LEN - 5'd1)) begin
                    fsm_d = ST_DONE;
                end else begin
                    fsm_d = ST_WALK;
                end
            end
            ST_DONE: begin
                fsm_d = ST_IDLE;
            end
            default: begin
                fsm_d = ST_IDLE;
            end
        endcase
        // Status flags are decoded from the next state so they leave a register.
        busy_d = (fsm_d == ST_PRIME) || (fsm_d == ST_WALK);
        done_d = (fsm_d == ST_DONE);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm_q   <= ST_IDLE;
            state_q <= '0;
            hold_q  <= '0;
            px_q    <= 3'd0;
            py_q    <= 3'd0;
            inv_q   <= 1'b0;
            step_q  <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            hold_q  <= hold_d;
            px_q    <= px_d;
            py_q    <= py_d;
            inv_q   <= inv_d;
            step_q  <= step_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign state_out = state_q;
    assign step_cnt  = step_q;

endmodule

// File: tb/tb_pi_lane_permuter.sv
// Self-checking bench for pi_lane_permuter: an 8-bit-lane instance with
// inverse support and a 1-bit-lane instance with inverse disabled, both
// compared against a lane-array reference model of pi and pi^-1.
module tb_pi_lane_permuter;

    logic         clk = 1'b0;
    logic         rst = 1'b0;

    logic         load8 = 1'b0, start8 = 1'b0, inv8 = 1'b0;
    logic [199:0] line8 = '0;
    logic         busy8, done8;
    logic [199:0] out8;
    logic [4:0]   cnt8;

    logic         load1 = 1'b0, start1 = 1'b0, inv1 = 1'b0;
    logic [24:0]  line1 = '0;
    logic         busy1, done1;
    logic [24:0]  out1;
    logic [4:0]   cnt1;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pi_lane_permuter #(.LANE_W(8), .INV_EN(1'b1)) u8 (
        .clk(clk), .rst(rst), .load(load8), .line_in(line8), .start(start8),
        .inverse(inv8), .busy(busy8), .done(done8), .state_out(out8), .step_cnt(cnt8)
    );

    pi_lane_permuter #(.LANE_W(1), .INV_EN(1'b0)) u1 (
        .clk(clk), .rst(rst), .load(load1), .line_in(line1), .start(start1),
        .inverse(inv1), .busy(busy1), .done(done1), .state_out(out1), .step_cnt(cnt1)
    );

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [199:0] rand200();
        logic [223:0] t;
        for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom();
        return t[199:0];
    endfunction

    // Reference: pi moves A[x][y] to B[y][(2x+3y) mod 5]; pi^-1 reads it back.
    function automatic logic [199:0] pi_ref(input logic [199:0] a, input bit inv);
        logic [199:0] b;
        int tx, ty;
        b = '0;
        for (int x = 0; x < 5; x++) begin
            for (int y = 0; y < 5; y++) begin
                tx = y;
                ty = (2 * x + 3 * y) % 5;
                if (!inv) b[(5*tx+ty)*8 +: 8] = a[(5*x+y)*8 +: 8];
                else      b[(5*x+y)*8 +: 8]   = a[(5*tx+ty)*8 +: 8];
            end
        end
        return b;
    endfunction

    // One permutation on the 8-bit instance; optionally pokes load/start mid-walk.
    task automatic run8(input logic [199:0] st, input bit do_load, input bit inv,
                        input bit poke, output logic [199:0] res);
        int bc, dc;
        logic [4:0] cnt_at_done;
        bc = 0; dc = 0; res = '0; cnt_at_done = 5'd0;
        if (do_load) begin
            load8 = 1'b1; line8 = st;
            tick();
            load8 = 1'b0;
        end
        start8 = 1'b1; inv8 = inv;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            inv8 = 1'($urandom_range(1));
            if (poke && i == 8)  begin start8 = 1'b1; load8 = 1'b1; line8 = rand200(); end
            if (poke && i == 9)  begin start8 = 1'b0; load8 = 1'b0; end
            if (busy8) bc++;
            if (done8) begin dc++; res = out8; cnt_at_done = cnt8; end
            tick();
        end
        check("busy_cycles", 200'(bc), 200'(25));
        check("done_count", 200'(dc), 200'(1));
        check("step_at_done", 200'(cnt_at_done), 200'(24));
    endtask

    task automatic run1(input bit inv, input string tag);
        int bc, dc;
        logic [24:0] res;
        bc = 0; dc = 0; res = '0;
        load1 = 1'b1; line1 = 25'd1 << 5;
        tick();
        load1 = 1'b0; start1 = 1'b1; inv1 = inv;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (busy1) bc++;
            if (done1) begin dc++; res = out1; end
            tick();
        end
        check({tag, "_result"}, 200'(res), 200'(25'd1 << 2));
        check({tag, "_busy"}, 200'(bc), 200'(25));
        check({tag, "_done"}, 200'(dc), 200'(1));
    endtask

    initial begin
        logic [199:0] st, r1, r2;
        bit inv, found;

        // Reset state
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        check("rst_busy", 200'(busy8), 200'(0));
        check("rst_done", 200'(done8), 200'(0));
        check("rst_state", out8, 200'(0));
        check("rst_step", 200'(cnt8), 200'(0));
        check("rst_state1", 200'(out1), 200'(0));

        // Single-bit lanes, inverse disabled: both requests yield forward pi
        run1(1'b0, "w1_fwd");
        run1(1'b1, "w1_invdis");

        // Forward then inverse restores the load; origin lane untouched
        st = rand200();
        run8(st, 1'b1, 1'b0, 1'b0, r1);
        check("fwd_result", r1, pi_ref(st, 1'b0));
        check("fwd_lane00", 200'(r1[7:0]), 200'(st[7:0]));
        check("step_hold_idle", 200'(cnt8), 200'(24));
        run8(st, 1'b0, 1'b1, 1'b0, r2);
        check("roundtrip", r2, st);
        check("rt_lane00", 200'(r2[7:0]), 200'(st[7:0]));

        // Random states in both modes
        for (int n = 0; n < 200; n++) begin
            st  = rand200();
            inv = 1'($urandom_range(1));
            run8(st, 1'b1, inv, 1'b0, r1);
            check(inv ? "rand_inv" : "rand_fwd", r1, pi_ref(st, inv));
        end

        // Reset in the middle of the walk
        st = rand200();
        load8 = 1'b1; line8 = st;
        tick();
        load8 = 1'b0; start8 = 1'b1; inv8 = 1'b0;
        tick();
        start8 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (cnt8 == 5'd10) found = 1'b1;
            else tick();
        end
        check("reach_step10", 200'(found), 200'(1));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("abort_busy", 200'(busy8), 200'(0));
        check("abort_done", 200'(done8), 200'(0));
        check("abort_state", out8, 200'(0));
        check("abort_step", 200'(cnt8), 200'(0));
        st = rand200();
        run8(st, 1'b1, 1'b1, 1'b0, r1);
        check("post_abort", r1, pi_ref(st, 1'b1));

        // Load and start together: load wins, no permutation starts
        st = rand200();
        load8 = 1'b1; start8 = 1'b1; line8 = st;
        tick();
        load8 = 1'b0; start8 = 1'b0;
        check("ls_state", out8, st);
        check("ls_busy", 200'(busy8), 200'(0));
        tick();
        check("ls_busy_later", 200'(busy8), 200'(0));
        check("ls_state_later", out8, st);

        // Load/start during the walk are ignored
        st = rand200();
        run8(st, 1'b1, 1'b0, 1'b1, r1);
        check("poke_result", r1, pi_ref(st, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
